// File: rtl/seq_detector_fsm_pkg.sv
// ---------------------------------------------------------------------------
// seq_det_pkg
// Shared definitions for the serial 1011 sequence detector.
//   state_t  : FSM state set (IDLE, S1, S10, S101, S1011)
//   PATTERN  : the detected bit pattern, oldest bit in the MSB
//   PAT_LEN  : number of bits in PATTERN
// ---------------------------------------------------------------------------
package seq_det_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        S1    = 3'd1,
        S10   = 3'd2,
        S101  = 3'd3,
        S1011 = 3'd4
    } state_t;

    localparam logic [3:0] PATTERN = 4'b1011;
    localparam int         PAT_LEN = 4;

endpackage

// File: rtl/seq_detector_fsm_if.sv
// ---------------------------------------------------------------------------
// seq_detector_fsm_if
// Serial sequence interface between a bit-stream source and the detector.
//   din  : serial data bit, driven by the source (master)
//   dout : one-cycle detection flag, driven by the detector (slave)
// Clock and reset are plain ports on the detector, not part of this bundle.
// ---------------------------------------------------------------------------
interface seq_detector_fsm_if;

    logic din;
    logic dout;

    modport master (
        output din,
        input  dout
    );

    modport slave (
        input  din,
        output dout
    );

endinterface

// File: rtl/seq_detector_fsm.sv
// ---------------------------------------------------------------------------
// seq_detector_fsm
// Moore FSM detecting the serial pattern 1011 on seq.din.
//   clock    : rising-edge system clock, one bit consumed per edge
//   reset    : asynchronous active-low reset (forces IDLE, dout=0)
//   seq      : slave modport; din in, dout out (one-cycle pulse per match)
// Parameter OVERLAP: 1 lets the tail of a match start the next match,
//                    0 restarts the search from scratch after a match.
// ---------------------------------------------------------------------------
module seq_detector_fsm
    import seq_det_pkg::*;
#(
    parameter int OVERLAP = 1
) (
    input  logic               clock,
    input  logic               reset,
    seq_detector_fsm_if.slave  seq
);

    state_t state;
    state_t next_state;
    logic   dout_q;

    // State register plus a dedicated output flop. The flop is loaded with
    // the decode of next_state, so it always equals (state == S1011) while
    // giving a glitch-free output with no combinational path from din.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            dout_q <= 1'b0;
        end else begin
            state  <= next_state;
            dout_q <= (next_state == S1011);
        end
    end

    // Next-state logic. Each state records the longest suffix of the input
    // seen so far that is also a prefix of 1011, so mismatches fall back to
    // the longest still-usable prefix instead of always returning to IDLE.
    always_comb begin
        next_state = IDLE;
        unique case (state)
            IDLE:  next_state = seq.din ? S1    : IDLE;
            S1:    next_state = seq.din ? S1    : S10;
            S10:   next_state = seq.din ? S101  : IDLE;
            S101:  next_state = seq.din ? S1011 : S10;
            S1011: begin
                // Overlapping mode reuses the trailing '1' of the match.
                if (OVERLAP != 0) begin
                    next_state = seq.din ? S1 : S10;
                end else begin
                    next_state = seq.din ? S1 : IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    assign seq.dout = dout_q;

endmodule

// File: tb/tb_seq_detector_fsm.sv
// ---------------------------------------------------------------------------
// tb_seq_detector_fsm
// Runs an overlapping and a non-overlapping detector side by side on the
// same bit stream and compares both against a pattern-matching reference
// model built from the bit history since reset / since the last match.
// ---------------------------------------------------------------------------
module tb_seq_detector_fsm;
    import seq_det_pkg::*;

    logic clock = 1'b0;
    logic reset;

    int compared   = 0;
    int mismatched = 0;

    // Reference model state: recent bits, bits since reset, bits since the
    // last non-overlapping match.
    logic [3:0] hist;
    int         since_rst;
    int         since_match;
    logic       exp_ov;
    logic       exp_nov;

    seq_detector_fsm_if if_ov ();
    seq_detector_fsm_if if_nov ();

    seq_detector_fsm #(.OVERLAP(1)) dut_ov (
        .clock (clock),
        .reset (reset),
        .seq   (if_ov)
    );

    seq_detector_fsm #(.OVERLAP(0)) dut_nov (
        .clock (clock),
        .reset (reset),
        .seq   (if_nov)
    );

    always #5 clock = ~clock;

    // Forget everything seen before reset.
    task automatic model_clear();
        hist        = 4'b0000;
        since_rst   = 0;
        since_match = 0;
        exp_ov      = 1'b0;
        exp_nov     = 1'b0;
    endtask

    // Called with clock low: present bit, let one rising edge consume it,
    // update the model, then return at the following falling edge.
    task automatic drive_bit(input logic b);
        if_ov.din  = b;
        if_nov.din = b;
        @(posedge clock);
        #1;
        hist        = {hist[2:0], b};
        since_rst   = since_rst + 1;
        since_match = since_match + 1;
        exp_ov      = (since_rst >= PAT_LEN) && (hist == PATTERN);
        exp_nov     = (since_match >= PAT_LEN) && (hist == PATTERN);
        if (exp_nov) since_match = 0;
        @(negedge clock);
    endtask

    // Two-cycle reset, released at a falling edge with din held at 0.
    task automatic apply_reset();
        if_ov.din  = 1'b0;
        if_nov.din = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        model_clear();
        repeat (2) @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        $display("[TB] test_reset");
        reset      = 1'b1;
        if_ov.din  = 1'b0;
        if_nov.din = 1'b0;
        #1 reset = 1'b0;
        model_clear();
        #1;
        compared++;
        if (if_ov.dout !== 1'b0 || if_nov.dout !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL reset_async: dout ov=%b nov=%b expected 0", if_ov.dout, if_nov.dout);
        end
        repeat (2) @(negedge clock);
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive_bit(1'b0);
            compared++;
            if (if_ov.dout !== 1'b0 || if_nov.dout !== 1'b0) begin
                mismatched++;
                $display("[TB] FAIL reset_idle bit %0d: dout ov=%b nov=%b expected 0", i, if_ov.dout, if_nov.dout);
            end
        end
    endtask

    // Plays a stream (MSB first), compares every cycle and counts pulses.
    task automatic test_stream(input string name, input logic [15:0] bits, input int n,
                               input int want_ov, input int want_nov);
        int p_ov;
        int p_nov;
        p_ov  = 0;
        p_nov = 0;
        $display("[TB] test_%s", name);
        apply_reset();
        for (int i = 0; i < n; i++) begin
            drive_bit(bits[n-1-i]);
            compared++;
            if (if_ov.dout !== exp_ov || if_nov.dout !== exp_nov) begin
                mismatched++;
                $display("[TB] FAIL %s edge %0d: dout ov=%b nov=%b expected ov=%b nov=%b",
                         name, i + 1, if_ov.dout, if_nov.dout, exp_ov, exp_nov);
            end
            if (if_ov.dout === 1'b1) p_ov++;
            if (if_nov.dout === 1'b1) p_nov++;
        end
        compared++;
        if (p_ov != want_ov || p_nov != want_nov) begin
            mismatched++;
            $display("[TB] FAIL %s_pulses: ov=%0d nov=%0d expected ov=%0d nov=%0d",
                     name, p_ov, p_nov, want_ov, want_nov);
        end
    endtask

    task automatic test_reset_mid();
        logic [3:0] post;
        post = 4'b1011;
        $display("[TB] test_reset_mid");
        apply_reset();
        drive_bit(1'b1);
        drive_bit(1'b0);
        drive_bit(1'b1);
        // Short low pulse between edges discards the "101" prefix.
        #1 reset = 1'b0;
        model_clear();
        #1 reset = 1'b1;
        drive_bit(1'b1);
        compared++;
        if (if_ov.dout !== 1'b0 || if_nov.dout !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL reset_mid_discard: dout ov=%b nov=%b expected 0", if_ov.dout, if_nov.dout);
        end
        for (int i = 0; i < 4; i++) begin
            drive_bit(post[3-i]);
            compared++;
            if (if_ov.dout !== (i == 3) || if_nov.dout !== (i == 3)) begin
                mismatched++;
                $display("[TB] FAIL reset_mid_post edge %0d: dout ov=%b nov=%b expected %b",
                         i + 1, if_ov.dout, if_nov.dout, (i == 3));
            end
        end
        // dout is high now; reset must clear it without a clock edge.
        #1 reset = 1'b0;
        model_clear();
        #1;
        compared++;
        if (if_ov.dout !== 1'b0 || if_nov.dout !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL reset_while_high: dout ov=%b nov=%b expected 0", if_ov.dout, if_nov.dout);
        end
        repeat (2) @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic test_random();
        $display("[TB] test_random");
        apply_reset();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 49) == 0) apply_reset();
            // Bias toward 1s so the pattern shows up often.
            drive_bit($urandom_range(0, 9) < 6);
            compared++;
            if (if_ov.dout !== exp_ov || if_nov.dout !== exp_nov) begin
                mismatched++;
                $display("[TB] FAIL random step %0d: dout ov=%b nov=%b expected ov=%b nov=%b",
                         i, if_ov.dout, if_nov.dout, exp_ov, exp_nov);
            end
        end
    endtask

    initial begin
        test_reset();
        test_stream("single",       16'b1011,        4,  1, 1);
        test_stream("back_to_back", 16'b1011011,     7,  2, 1);
        test_stream("nov_restart",  16'b10110111011, 11, 3, 2);
        test_stream("extra_ones",   16'b111011,      6,  1, 1);
        test_stream("broken_pref",  16'b1001011,     7,  1, 1);
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
